regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//  Shares the single RegFile write port between three writeback sources: ALU result, memory load and jump-link (Ra).
//  Arbitrates round-robin, registers the winning write and drives regWriteEn/RaWriteEn/Rdest/writeData into RegFile.
//  Keeps a 32-bit pending-write scoreboard so decode can stall on RAW hazards.
//  Sits between the execute/memory stages and RegFile.
// PARAMETERS
//  DATA_W    32  writeData / request data width
//  ADDR_W    5   register index width (32 registers)
//  RA_INDEX  31  register index written by the link channel
// PORTS
//  clk        in   1       rising-edge clock
//  reset      in   1       asynchronous, active-low reset (asserted when 0)
//  alu_valid  in   1       ALU write request
//  alu_ready  out  1       ALU request accepted this cycle
//  alu_dest   in   ADDR_W  ALU destination register
//  alu_data   in   DATA_W  ALU result
//  mem_valid  in   1       load write request
//  mem_ready  out  1       load request accepted this cycle
//  mem_dest   in   ADDR_W  load destination register
//  mem_data   in   DATA_W  load data
//  lnk_valid  in   1       link write request (dest fixed at RA_INDEX)
//  lnk_ready  out  1       link request accepted this cycle
//  lnk_data   in   DATA_W  return address
//  alloc_en   in   1       decode marks alloc_reg as having a write in flight
//  alloc_reg  in   ADDR_W  register being allocated
//  busy       out  32      scoreboard; bit i = write to Ri pending
//  regWriteEn out  1       RegFile general write enable
//  RaWriteEn  out  1       RegFile Ra write enable
//  Rdest      out  ADDR_W  RegFile write index
//  writeData  out  DATA_W  RegFile write data
// BEHAVIOUR
//  Reset (async, reset==0): regWriteEn=0, RaWriteEn=0, Rdest=0, writeData=0, busy=0, all *_ready=0,
//   rr pointer=ALU. Any in-flight grant is discarded.
//  Handshake: transfer when valid&&ready. ready is combinational and equals the grant; it may depend on valid.
//   Requesters hold valid/dest/data stable until accepted. At most one ready high per cycle.
//  Arbitration: fixed order ALU->MEM->LNK. Search starts at the pointer. On a grant, the pointer moves to the
//   channel after the winner. With no grant, the pointer holds. Example: all three valid continuously -> ALU,MEM,LNK,ALU...
//  Commit register (latency 1): request accepted in cycle N -> enable high for exactly cycle N+1.
//   ALU/MEM: regWriteEn=(dest!=0), RaWriteEn=0, Rdest=dest, writeData=data. A write to R0 is accepted and dropped.
//   ALU/MEM dest==RA_INDEX is legal and uses regWriteEn.
//   LNK: regWriteEn=0, RaWriteEn=1, Rdest=RA_INDEX, writeData=lnk_data.
//   No grant: both enables 0; Rdest/writeData hold their previous values.
//  Back-to-back grants yield one write per cycle, with no bubble. Same-dest writes commit in grant order; the later write wins.
//  Scoreboard, evaluated each edge:
//   - set busy[alloc_reg] if alloc_en && alloc_reg!=0;
//   - clear busy[Rdest] in the cycle its enable (regWriteEn or RaWriteEn) is high.
//   - Set and clear of the same bit in the same cycle: set wins.
//   - busy[0] is constant 0.
//   - Clearing an already-clear bit is a no-op.
// STRUCTURE
//  titan_defs.vh: DATA_W, ADDR_W, RA_INDEX, channel encodings CH_ALU=0, CH_MEM=1, CH_LNK=2.
//  Sub-module rr_arbiter3: 3-way round-robin grant plus pointer register. Commit register and scoreboard stay in the top module.
// TESTING
//  1. Reset low mid-grant -> all outputs 0 and busy=0 immediately; after release, first grant goes to ALU.
//  2. alu_valid, dest=2, data=41 -> alu_ready same cycle; next cycle regWriteEn=1, Rdest=2, writeData=41.
//  3. alu(dest 3), mem(dest 4) and lnk(0x400) valid and held -> grants ALU,MEM,LNK on consecutive cycles.
//     LNK commit: RaWriteEn=1, Rdest=31.
//  4. alu_valid, dest=0, data=7 -> alu_ready=1; next cycle regWriteEn=0, RaWriteEn=0.
//  5. alloc_en, reg 5, then ALU write to R5 -> busy[5]=1 until the commit cycle, 0 after.
//     alloc R5 in the commit cycle -> busy[5] stays 1.
//  6. MEM valid alone for 3 cycles with ALU arriving in cycle 2 -> MEM granted in cycle 1, ALU in cycle 2, MEM in cycle 3.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the RegFile writeback arbiter: widths, link register
// index and the writeback channel encoding.
package regfile_wb_arbiter_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int RA_INDEX = 31;
    localparam int NUM_REGS = 1 << ADDR_W;
    localparam int NUM_CH   = 3;

    typedef enum logic [1:0] {
        CH_ALU = 2'd0,
        CH_MEM = 2'd1,
        CH_LNK = 2'd2
    } channel_t;

    // Round-robin successor: ALU -> MEM -> LNK -> ALU.
    function automatic channel_t nextChannel(input channel_t ch);
        case (ch)
            CH_ALU:  return CH_MEM;
            CH_MEM:  return CH_LNK;
            default: return CH_ALU;
        endcase
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter3.sv
// Three-way round-robin arbiter. The search starts at the pointer; after a
// grant the pointer moves to the channel following the winner.
module rr_arbiter3
    import regfile_wb_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] req,
    output logic [NUM_CH-1:0] grant,
    output logic              grantValid,
    output channel_t          winner
);

    channel_t ptr;
    channel_t firstCh;
    channel_t secondCh;
    channel_t thirdCh;

    // Pick the first requesting channel in rotated order; nothing is granted while in reset.
    always_comb begin
        // NOTE: every output gets a default before any branch, so no path leaves a latch behind.
        grant      = '0;
        grantValid = 1'b0;
        winner     = ptr;
        firstCh    = ptr;
        secondCh   = nextChannel(ptr);
        thirdCh    = nextChannel(secondCh);
        if (reset) begin
            if (req[firstCh]) begin
                winner     = firstCh;
                grantValid = 1'b1;
            end else if (req[secondCh]) begin
                winner     = secondCh;
                grantValid = 1'b1;
            end else if (req[thirdCh]) begin
                winner     = thirdCh;
                grantValid = 1'b1;
            end
            if (grantValid) begin
                grant[winner] = 1'b1;
            end
        end
    end

    // Advance the pointer past the winner; hold it when nothing is granted.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (!reset) begin
            ptr <= CH_ALU;
        end else if (grantValid) begin
            ptr <= nextChannel(winner);
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the single RegFile write port between ALU, load and link writebacks.
// The winning request is registered for one cycle and drives the RegFile;
// a pending-write scoreboard lets decode stall on RAW hazards.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                alu_valid,
    output logic                alu_ready,
    input  logic [ADDR_W-1:0]   alu_dest,
    input  logic [DATA_W-1:0]   alu_data,
    input  logic                mem_valid,
    output logic                mem_ready,
    input  logic [ADDR_W-1:0]   mem_dest,
    input  logic [DATA_W-1:0]   mem_data,
    input  logic                lnk_valid,
    output logic                lnk_ready,
    input  logic [DATA_W-1:0]   lnk_data,
    input  logic                alloc_en,
    input  logic [ADDR_W-1:0]   alloc_reg,
    output logic [NUM_REGS-1:0] busy,
    output logic                regWriteEn,
    output logic                RaWriteEn,
    output logic [ADDR_W-1:0]   Rdest,
    output logic [DATA_W-1:0]   writeData
);

    logic [NUM_CH-1:0]   req;
    logic [NUM_CH-1:0]   grant;
    logic                grantValid;
    channel_t            winner;
    logic [NUM_REGS-1:0] busyNext;

    assign req = {lnk_valid, mem_valid, alu_valid};

    rr_arbiter3 u_arb (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .grant     (grant),
        .grantValid(grantValid),
        .winner    (winner)
    );

    assign alu_ready = grant[CH_ALU];
    assign mem_ready = grant[CH_MEM];
    assign lnk_ready = grant[CH_LNK];

    // Register the accepted write; enables last one cycle, index/data hold when idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            regWriteEn <= 1'b0;
            RaWriteEn  <= 1'b0;
            Rdest      <= '0;
            writeData  <= '0;
        end else begin
            regWriteEn <= 1'b0;
            RaWriteEn  <= 1'b0;
            if (grantValid) begin
                case (winner)
                    CH_ALU: begin
                        regWriteEn <= (alu_dest != '0);
                        Rdest      <= alu_dest;
                        writeData  <= alu_data;
                    end
                    CH_MEM: begin
                        regWriteEn <= (mem_dest != '0);
                        Rdest      <= mem_dest;
                        writeData  <= mem_data;
                    end
                    default: begin
                        RaWriteEn <= 1'b1;
                        Rdest     <= ADDR_W'(RA_INDEX);
                        writeData <= lnk_data;
                    end
                endcase
            end
        end
    end

    // Scoreboard update: clear on commit, then set on allocate so a same-cycle set wins.
    always_comb begin
        busyNext = busy;
        if (regWriteEn || RaWriteEn) begin
            busyNext[Rdest] = 1'b0;
        end
        if (alloc_en && (alloc_reg != '0)) begin
            busyNext[alloc_reg] = 1'b1;
        end
        busyNext[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: busy is a flop vector rather than a RAM, so it takes the reset and starts clean.
        if (!reset) begin
            busy <= '0;
        end else begin
            busy <= busyNext;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, single writes, round-robin
// rotation, R0 drop, scoreboard set/clear and late-arriving requesters.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid, mem_valid, lnk_valid, alloc_en;
    logic        alu_ready, mem_ready, lnk_ready;
    logic [4:0]  alu_dest, mem_dest, alloc_reg;
    logic [31:0] alu_data, mem_data, lnk_data;
    logic [31:0] busy;
    logic        regWriteEn, RaWriteEn;
    logic [4:0]  Rdest;
    logic [31:0] writeData;

    int errCount   = 0;
    int checkCount = 0;

    regfile_wb_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_dest  (alu_dest),
        .alu_data  (alu_data),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_dest  (mem_dest),
        .mem_data  (mem_data),
        .lnk_valid (lnk_valid),
        .lnk_ready (lnk_ready),
        .lnk_data  (lnk_data),
        .alloc_en  (alloc_en),
        .alloc_reg (alloc_reg),
        .busy      (busy),
        .regWriteEn(regWriteEn),
        .RaWriteEn (RaWriteEn),
        .Rdest     (Rdest),
        .writeData (writeData)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errCount++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Readies packed as {alu, mem, lnk}; enables packed as {regWriteEn, RaWriteEn}.
    function automatic logic [31:0] readies();
        return 32'({alu_ready, mem_ready, lnk_ready});
    endfunction

    function automatic logic [31:0] enables();
        return 32'({regWriteEn, RaWriteEn});
    endfunction

    initial begin
        reset     = 1'b0;
        alu_valid = 0; mem_valid = 0; lnk_valid = 0; alloc_en = 0;
        alu_dest  = 0; mem_dest  = 0; alloc_reg = 0;
        alu_data  = 0; mem_data  = 0; lnk_data  = 0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_enables", enables(), 0);
        check("rst_readies", readies(), 0);
        check("rst_rdest", 32'(Rdest), 0);
        check("rst_wdata", writeData, 0);
        check("rst_busy", busy, 0);
        reset = 1'b1;

        // Single ALU write to R2, with an allocation of R9 alongside.
        alu_valid = 1; alu_dest = 2; alu_data = 41; alloc_en = 1; alloc_reg = 9;
        #1;
        check("t2_ready", readies(), 32'b100);
        step();
        alu_valid = 0; alloc_en = 0;
        check("t2_enables", enables(), 32'b10);
        check("t2_rdest", 32'(Rdest), 2);
        check("t2_wdata", writeData, 41);
        check("t2_busy", busy, 32'h200);
        step();
        check("idle_enables", enables(), 0);
        check("idle_rdest_hold", 32'(Rdest), 2);
        check("idle_wdata_hold", writeData, 41);

        // All three requesting; pointer sits at MEM after the ALU grant.
        alu_valid = 1; alu_dest = 3; alu_data = 32'h33;
        mem_valid = 1; mem_dest = 4; mem_data = 32'h44;
        lnk_valid = 1; lnk_data = 32'h400;
        #1;
        check("t1_ready_mem", readies(), 32'b010);
        step();
        check("t1_mem_commit", enables(), 32'b10);
        check("t1_mem_rdest", 32'(Rdest), 4);

        // Reset in the middle of a commit and a pending LNK grant.
        reset = 1'b0;
        #1;
        check("t1_rst_enables", enables(), 0);
        check("t1_rst_readies", readies(), 0);
        check("t1_rst_rdest", 32'(Rdest), 0);
        check("t1_rst_wdata", writeData, 0);
        check("t1_rst_busy", busy, 0);
        reset = 1'b1;
        #1;
        check("t1_first_alu", readies(), 32'b100);

        // Rotation ALU -> MEM -> LNK -> ALU with all requests held.
        step();
        check("t3_alu_enables", enables(), 32'b10);
        check("t3_alu_rdest", 32'(Rdest), 3);
        check("t3_alu_wdata", writeData, 32'h33);
        check("t3_ready_mem", readies(), 32'b010);
        step();
        check("t3_mem_enables", enables(), 32'b10);
        check("t3_mem_rdest", 32'(Rdest), 4);
        check("t3_mem_wdata", writeData, 32'h44);
        check("t3_ready_lnk", readies(), 32'b001);
        step();
        check("t3_lnk_enables", enables(), 32'b01);
        check("t3_lnk_rdest", 32'(Rdest), 31);
        check("t3_lnk_wdata", writeData, 32'h400);
        check("t3_ready_wrap", readies(), 32'b100);
        alu_valid = 0; mem_valid = 0; lnk_valid = 0;
        #1;
        check("t3_ready_none", readies(), 0);
        step();
        check("t3_idle_enables", enables(), 0);

        // Write to R0 is accepted but dropped.
        alu_valid = 1; alu_dest = 0; alu_data = 7;
        #1;
        check("t4_ready", readies(), 32'b100);
        step();
        alu_valid = 0;
        check("t4_enables", enables(), 0);
        check("t4_wdata", writeData, 7);

        // Scoreboard: allocate R5, R0 never sets, ALU write to R5 clears after commit.
        alloc_en = 1; alloc_reg = 5;
        step();
        alloc_reg = 0;
        check("t5_alloc", busy, 32'h20);
        step();
        alloc_en = 0;
        check("t5_alloc_r0", busy, 32'h20);
        alu_valid = 1; alu_dest = 5; alu_data = 32'h55;
        #1;
        check("t5_ready", readies(), 32'b100);
        step();
        alu_valid = 0;
        check("t5_commit_enables", enables(), 32'b10);
        check("t5_commit_rdest", 32'(Rdest), 5);
        check("t5_busy_in_commit", busy, 32'h20);
        step();
        check("t5_busy_cleared", busy, 0);

        // Allocate again; re-allocate R5 during its commit cycle so set wins.
        alloc_en = 1; alloc_reg = 5;
        alu_valid = 1; alu_dest = 5; alu_data = 32'h56;
        #1;
        check("t5b_ready", readies(), 32'b100);
        step();
        alu_valid = 0;
        check("t5b_commit_enables", enables(), 32'b10);
        check("t5b_busy_in_commit", busy, 32'h20);
        step();
        alloc_en = 0;
        check("t5b_set_wins", busy, 32'h20);
        step();
        check("t5b_busy_holds", busy, 32'h20);

        // MEM alone, ALU arrives in the second cycle: MEM, ALU, MEM.
        mem_valid = 1; mem_dest = 6; mem_data = 32'h60;
        #1;
        check("t6_c1_ready", readies(), 32'b010);
        step();
        mem_data = 32'h61;
        alu_valid = 1; alu_dest = 8; alu_data = 32'h88;
        check("t6_c1_rdest", 32'(Rdest), 6);
        check("t6_c1_wdata", writeData, 32'h60);
        #1;
        check("t6_c2_ready", readies(), 32'b100);
        step();
        alu_valid = 0;
        check("t6_c2_rdest", 32'(Rdest), 8);
        check("t6_c2_wdata", writeData, 32'h88);
        #1;
        check("t6_c3_ready", readies(), 32'b010);
        step();
        mem_valid = 0;
        check("t6_c3_enables", enables(), 32'b10);
        check("t6_c3_rdest", 32'(Rdest), 6);
        check("t6_c3_wdata", writeData, 32'h61);
        step();
        check("t6_idle_enables", enables(), 0);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
